cabac_se_prepare_intra_luma_nxn: RTL and testbench
==================================================

# cabac_se_prepare_intra_luma_nxn

Sequential intra-luma syntax-element preparer for CABAC. For each intra CU it handles one PU (2Nx2N) or four PUs (NxN). It derives the three most-probable-mode candidates per PU, resolving intra-CU neighbours internally (PU0→PU1, PU0→PU2, PU1/PU2→PU3). It then streams packed SE words to the CABAC binarizer over a valid/ready handshake, in standard order: all `prev_intra_luma_pred_flag` words first, then all `mpm_idx` / `rem_intra_luma_pred_mode` words.

## Interface
Parameters:
- `PU_NUM_MAX`, 4: maximum PUs per CU; only 4 is supported.
- `MODE_W`, 6: luma mode width.
- `SE_W`, 21: packed SE word width, laid out as {value[7:0], bin_num[3:0], ctx_or_type[8:0]}.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  one-cycle pulse; inputs are sampled on this cycle.
- `part_nxn_i`  in  1  0 = one PU (PU0 only), 1 = four PUs.
- `cur_mode_i`  in  4*MODE_W  current modes; PUk occupies bits [k*MODE_W +: MODE_W].
- `left_mode_i`  in  2*MODE_W  external left neighbours; [0] is for PU0, [1] is for PU2. Caller substitutes 1 (DC) when unavailable.
- `top_mode_i`  in  2*MODE_W  external top neighbours; [0] is for PU0, [1] is for PU1. Caller substitutes 1 (DC) when unavailable or outside the CTU.
- `busy_o`  out  1  high from the cycle after an accepted start until the cycle after the last handshake.
- `se_valid_o`  out  1  SE word valid.
- `se_data_o`  out  SE_W  SE word.
- `se_last_o`  out  1  marks the final word of the CU.
- `se_ready_i`  in  1  consumer ready.
- `done_o`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, CALC, FLAG, MODE, DONE.
- IDLE: `start_i` is accepted. Inputs are latched, N = 4 if `part_nxn_i` else 1, PU counter = 0, and the state moves to CALC. `start_i` in any other state is ignored.
- CALC: one PU per cycle. Neighbours used:
  - PU0: external left[0] and top[0].
  - PU1: left = cur PU0, top = top[1].
  - PU2: left = left[1], top = cur PU0.
  - PU3: left = cur PU2, top = cur PU1.
- Candidate derivation (L = left, T = top):
  - L == T and L ≥ 2: {L, ((L+29)&31)+2, ((L−1)&31)+2}.
  - L == T and L < 2: {0, 1, 26}.
  - L ≠ T: {L, T, X}. X = 0 if neither L nor T is 0; otherwise X = 26 if L+T < 2, else 1.
- MPM index: match cur against cand2, then cand1, then cand0, in that priority order.
  - Match: flag = 1, idx = position of the match.
  - No match: flag = 0. Sort the candidates ascending as s0 < s1 < s2. Take rem = cur, then step through s2, s1, s0, decrementing rem each time rem exceeds that value. rem is 5 bits.
- Results go into a per-PU register file (flag, 5-bit value). After PU N−1 the state moves to FLAG.
- FLAG: emits N words, PU0 first. Each word is {7'h0, flag, 4'h1, 9'h00e}.
- MODE: emits N words, PU0 first.
  - Flag = 1: {3'h0, idx[4:0], 4'h2, 9'h0bd}.
  - Flag = 0: {3'h0, rem[4:0], 4'h5, 9'h0bb}.
  - `se_last_o` is high on the final MODE word.
- DONE: `done_o` pulses for one cycle, then the state returns to IDLE.
- Reset (any time, including mid-CU): state = IDLE and all outputs = 0. The partial CU is discarded.

## Timing
- Outputs are registered. `se_data_o` and `se_last_o` update only after a handshake.
- CALC takes N cycles. The first `se_valid_o` appears N+1 cycles after `start_i`.
- With `se_ready_i` held high, one word is emitted per cycle:
  - 2Nx2N: 2 words; `done_o` at start + 4.
  - NxN: 8 words; `done_o` at start + 13.
- Handshake occurs when `se_valid_o` and `se_ready_i` are both high on a rising edge.
- While valid and not ready, `se_data_o` and `se_last_o` hold stable and valid stays high.
- Valid never drops without a handshake.
- `se_ready_i` has no effect when `se_valid_o` is low.
- Back-to-back CUs: a new start is accepted at the earliest in the IDLE cycle after `done_o`.

## Test plan
- Reset: hold `rst_n` = 0. All outputs = 0, `busy_o` = 0.
- 2Nx2N, L = T = 26, cur = 26. Candidates {26, 25, 27}, idx 0. Words are 0x0220E then 0x004BD. `se_last_o` is on word 2; `done_o` at start + 4.
- 2Nx2N, L = 0, T = 1, cur = 10. Candidates {0, 1, 26}, rem = 8. Words are 0x0020E then 0x10ABB.
- NxN, all cur = 0, left = {0, 0}, top[0] = 0, top[1] = 10. PU1 candidates are {0, 10, 1}, idx 0. Output is four 0x0220E words, then four 0x004BD words, `se_last_o` on the eighth word only.
- Back-pressure: repeat the NxN case with `se_ready_i` toggling 1010…. Data is stable during stalls, the word sequence is unchanged, and `done_o` follows the last accepted word.
- Assert `rst_n` = 0 during FLAG, then start a new CU with the 2Nx2N idx-0 case. Only that CU's 2 words appear, and a start pulsed while busy is ignored.

Source files
------------

// File: rtl/cabac_se_prepare_intra_luma_nxn.sv
`default_nettype none
// ============================================================================
// Module   : cabac_se_prepare_intra_luma_nxn
// Purpose  : Intra-luma MPM derivation and SE word streaming for CABAC.
// Revision : 1.0
// ============================================================================
module cabac_se_prepare_intra_luma_nxn #(
    parameter int PU_NUM_MAX = 4,
    parameter int MODE_W     = 6,
    parameter int SE_W       = 21
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         part_nxn_i,
    input  logic [PU_NUM_MAX*MODE_W-1:0] cur_mode_i,
    input  logic [2*MODE_W-1:0]          left_mode_i,
    input  logic [2*MODE_W-1:0]          top_mode_i,
    output logic                         busy_o,
    output logic                         se_valid_o,
    output logic [SE_W-1:0]              se_data_o,
    output logic                         se_last_o,
    input  logic                         se_ready_i,
    output logic                         done_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FLAG = 3'd2,
        S_MODE = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic                           nxn_q, nxn_d;
    logic [1:0]                     pu_q, pu_d;
    logic [PU_NUM_MAX*MODE_W-1:0]   cur_q, cur_d;
    logic [2*MODE_W-1:0]            left_q, left_d;
    logic [2*MODE_W-1:0]            top_q, top_d;
    logic [PU_NUM_MAX-1:0]          flag_q, flag_d;
    logic [PU_NUM_MAX-1:0][4:0]     val_q, val_d;
    logic                           busy_q, busy_d;
    logic                           valid_q, valid_d;
    logic [SE_W-1:0]                data_q, data_d;
    logic                           last_q, last_d;
    logic                           done_q, done_d;

    logic [MODE_W-1:0]              calc_cur, calc_l, calc_t;
    logic [5:0]                     calc_code;
    logic [1:0]                     last_pu;
    logic [1:0]                     pu_inc;
    logic                           hs;

    // Returns {flag, idx_or_rem[4:0]} for one PU.
    function automatic logic [5:0] mpm_code(input logic [MODE_W-1:0] cur,
                                            input logic [MODE_W-1:0] l,
                                            input logic [MODE_W-1:0] t);
        logic [MODE_W-1:0] c0, c1, c2, s0, s1, s2, tmp, rem;
        logic [MODE_W:0]   sum;
        sum = {1'b0, l} + {1'b0, t};
        if (l == t) begin
            if (l >= MODE_W'(2)) begin
                c0 = l;
                c1 = ((l + MODE_W'(29)) & MODE_W'(31)) + MODE_W'(2);
                c2 = ((l - MODE_W'(1)) & MODE_W'(31)) + MODE_W'(2);
            end else begin
                c0 = MODE_W'(0);
                c1 = MODE_W'(1);
                c2 = MODE_W'(26);
            end
        end else begin
            c0 = l;
            c1 = t;
            if ((l != MODE_W'(0)) && (t != MODE_W'(0)))
                c2 = MODE_W'(0);
            else if (sum < (MODE_W+1)'(2))
                c2 = MODE_W'(26);
            else
                c2 = MODE_W'(1);
        end
        if (cur == c2) return {1'b1, 5'd2};
        if (cur == c1) return {1'b1, 5'd1};
        if (cur == c0) return {1'b1, 5'd0};
        s0 = c0;
        s1 = c1;
        s2 = c2;
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
        if (s1 > s2) begin tmp = s1; s1 = s2; s2 = tmp; end
        if (s0 > s1) begin tmp = s0; s0 = s1; s1 = tmp; end
        rem = cur;
        if (rem > s2) rem = rem - MODE_W'(1);
        if (rem > s1) rem = rem - MODE_W'(1);
        if (rem > s0) rem = rem - MODE_W'(1);
        return {1'b0, rem[4:0]};
    endfunction

    function automatic logic [SE_W-1:0] flag_word(input logic f);
        return {7'h00, f, 4'h1, 9'h00e};
    endfunction

    function automatic logic [SE_W-1:0] mode_word(input logic f, input logic [4:0] v);
        return f ? {3'h0, v, 4'h2, 9'h0bd} : {3'h0, v, 4'h5, 9'h0bb};
    endfunction

    // Intra-CU neighbours come from already-latched current modes.
    always_comb begin
        calc_cur = cur_q[0 +: MODE_W];
        calc_l   = left_q[0 +: MODE_W];
        calc_t   = top_q[0 +: MODE_W];
        case (pu_q)
            2'd0: begin
                calc_cur = cur_q[0 +: MODE_W];
                calc_l   = left_q[0 +: MODE_W];
                calc_t   = top_q[0 +: MODE_W];
            end
            2'd1: begin
                calc_cur = cur_q[MODE_W +: MODE_W];
                calc_l   = cur_q[0 +: MODE_W];
                calc_t   = top_q[MODE_W +: MODE_W];
            end
            2'd2: begin
                calc_cur = cur_q[2*MODE_W +: MODE_W];
                calc_l   = left_q[MODE_W +: MODE_W];
                calc_t   = cur_q[0 +: MODE_W];
            end
            default: begin
                calc_cur = cur_q[3*MODE_W +: MODE_W];
                calc_l   = cur_q[2*MODE_W +: MODE_W];
                calc_t   = cur_q[MODE_W +: MODE_W];
            end
        endcase
    end

    assign calc_code = mpm_code(calc_cur, calc_l, calc_t);
    assign last_pu   = nxn_q ? 2'd3 : 2'd0;
    assign pu_inc    = pu_q + 2'd1;
    assign hs        = valid_q & se_ready_i;

    always_comb begin
        state_d = state_q;
        nxn_d   = nxn_q;
        pu_d    = pu_q;
        cur_d   = cur_q;
        left_d  = left_q;
        top_d   = top_q;
        flag_d  = flag_q;
        val_d   = val_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cur_d   = cur_mode_i;
                    left_d  = left_mode_i;
                    top_d   = top_mode_i;
                    nxn_d   = part_nxn_i;
                    pu_d    = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                flag_d[pu_q] = calc_code[5];
                val_d[pu_q]  = calc_code[4:0];
                if (pu_q == last_pu) begin
                    // flag_d[0] already holds this cycle's result when N is 1.
                    pu_d    = 2'd0;
                    valid_d = 1'b1;
                    data_d  = flag_word(flag_d[0]);
                    last_d  = 1'b0;
                    state_d = S_FLAG;
                end else begin
                    pu_d = pu_inc;
                end
            end
            S_FLAG: begin
                if (hs) begin
                    if (pu_q == last_pu) begin
                        pu_d    = 2'd0;
                        data_d  = mode_word(flag_q[0], val_q[0]);
                        last_d  = ~nxn_q;
                        state_d = S_MODE;
                    end else begin
                        pu_d   = pu_inc;
                        data_d = flag_word(flag_q[pu_inc]);
                    end
                end
            end
            S_MODE: begin
                if (hs) begin
                    if (pu_q == last_pu) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pu_d   = pu_inc;
                        data_d = mode_word(flag_q[pu_inc], val_q[pu_inc]);
                        last_d = (pu_inc == last_pu);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nxn_q   <= 1'b0;
            pu_q    <= 2'd0;
            cur_q   <= '0;
            left_q  <= '0;
            top_q   <= '0;
            flag_q  <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nxn_q   <= nxn_d;
            pu_q    <= pu_d;
            cur_q   <= cur_d;
            left_q  <= left_d;
            top_q   <= top_d;
            flag_q  <= flag_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign se_valid_o = valid_q;
    assign se_data_o  = data_q;
    assign se_last_o  = last_q;
    assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cabac_se_prepare_intra_luma_nxn.sv
`default_nettype none
// ============================================================================
// Module   : tb_cabac_se_prepare_intra_luma_nxn
// Purpose  : Scoreboard bench with directed CUs, back-pressure and reset abort.
// Revision : 1.0
// ============================================================================
module tb_cabac_se_prepare_intra_luma_nxn;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        part_nxn_i;
    logic [23:0] cur_mode_i;
    logic [11:0] left_mode_i;
    logic [11:0] top_mode_i;
    logic        busy_o;
    logic        se_valid_o;
    logic [20:0] se_data_o;
    logic        se_last_o;
    logic        se_ready_i;
    logic        done_o;

    always #5 clk = ~clk;

    cabac_se_prepare_intra_luma_nxn #(
        .PU_NUM_MAX (4),
        .MODE_W     (6),
        .SE_W       (21)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .part_nxn_i  (part_nxn_i),
        .cur_mode_i  (cur_mode_i),
        .left_mode_i (left_mode_i),
        .top_mode_i  (top_mode_i),
        .busy_o      (busy_o),
        .se_valid_o  (se_valid_o),
        .se_data_o   (se_data_o),
        .se_last_o   (se_last_o),
        .se_ready_i  (se_ready_i),
        .done_o      (done_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
    logic [21:0] exp_q[$];         // {last, data}

    initial begin
        se_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       se_ready_i = 1'b1;
                1:       se_ready_i = ~se_ready_i;
                default: se_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every handshake, checks stall stability and done timing.
    initial begin
        logic        stall_pend;
        logic [20:0] stall_data;
        logic        stall_last;
        logic        done_exp;
        logic [21:0] e;
        stall_pend = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        done_exp   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
                done_exp   = 1'b0;
            end else begin
                if (done_exp) begin
                    checks++;
                    if (!done_o) begin
                        errors++;
                        $display("FAIL done_after_last: done_o=%0b required 1", done_o);
                    end
                    done_exp = 1'b0;
                end else if (done_o) begin
                    checks++;
                    errors++;
                    $display("FAIL done_spurious: done_o=1 required 0");
                end
                if (stall_pend) begin
                    checks++;
                    if (!se_valid_o || se_data_o != stall_data || se_last_o != stall_last) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b data=%05h last=%0b required valid=1 data=%05h last=%0b",
                                 se_valid_o, se_data_o, se_last_o, stall_data, stall_last);
                    end
                end
                stall_pend = 1'b0;
                if (se_valid_o && se_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: data=%05h last=%0b required none", se_data_o, se_last_o);
                    end else begin
                        e = exp_q.pop_front();
                        if ({se_last_o, se_data_o} != e) begin
                            errors++;
                            $display("FAIL word: data=%05h last=%0b required data=%05h last=%0b",
                                     se_data_o, se_last_o, e[20:0], e[21]);
                        end
                    end
                    if (se_last_o) done_exp = 1'b1;
                end else if (se_valid_o) begin
                    stall_pend = 1'b1;
                    stall_data = se_data_o;
                    stall_last = se_last_o;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  {31'd0, busy_o},     32'd0);
        check({tag, "_valid"}, {31'd0, se_valid_o}, 32'd0);
        check({tag, "_data"},  {11'd0, se_data_o},  32'd0);
        check({tag, "_last"},  {31'd0, se_last_o},  32'd0);
        check({tag, "_done"},  {31'd0, done_o},     32'd0);
    endtask

    task automatic push(input logic last, input logic [20:0] d);
        exp_q.push_back({last, d});
    endtask

    // exp_done: cycles from start to done_o (0 skips the latency check).
    task automatic run_cu(input string name, input logic nxn, input logic [23:0] cur,
                          input logic [11:0] left, input logic [11:0] top,
                          input int exp_done, input bit pulse_busy_start);
        int k;
        bit got;
        @(posedge clk);
        #1;
        part_nxn_i  = nxn;
        cur_mode_i  = cur;
        left_mode_i = left;
        top_mode_i  = top;
        start_i     = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k   = 0;
        got = 1'b0;
        while (k < 200 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) check({name, "_busy_early"}, {31'd0, busy_o}, 32'd1);
            if (pulse_busy_start && k == 2) begin
                start_i     = 1'b1;
                part_nxn_i  = 1'b1;
                cur_mode_i  = 24'h3ffff0;
                left_mode_i = 12'h0c3;
                top_mode_i  = 12'h105;
            end
            if (pulse_busy_start && k == 3) start_i = 1'b0;
            if (done_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, k);
        end else begin
            if (exp_done > 0) check({name, "_done_latency"}, k, exp_done);
            check({name, "_busy_at_done"}, {31'd0, busy_o}, 32'd1);
            @(negedge clk);
            check({name, "_busy_after"}, {31'd0, busy_o}, 32'd0);
            check({name, "_queue_empty"}, exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        int k;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        part_nxn_i  = 1'b0;
        cur_mode_i  = '0;
        left_mode_i = '0;
        top_mode_i  = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // L=T=26, cur=26 -> idx 0
        push(1'b0, 21'h0220E);
        push(1'b1, 21'h004BD);
        run_cu("p2n_idx0", 1'b0, {18'd0, 6'd26}, {6'd0, 6'd26}, {6'd0, 6'd26}, 4, 1'b0);

        // L=0, T=1, cur=10 -> rem 8
        push(1'b0, 21'h0020E);
        push(1'b1, 21'h10ABB);
        run_cu("p2n_rem8", 1'b0, {18'd0, 6'd10}, {6'd0, 6'd0}, {6'd0, 6'd1}, 4, 1'b0);

        // L=T=26, cur=27 -> idx 2
        push(1'b0, 21'h0220E);
        push(1'b1, 21'h044BD);
        run_cu("p2n_idx2", 1'b0, {18'd0, 6'd27}, {6'd0, 6'd26}, {6'd0, 6'd26}, 4, 1'b0);

        // L=10, T=20, cur=20 -> idx 1
        push(1'b0, 21'h0220E);
        push(1'b1, 21'h024BD);
        run_cu("p2n_idx1", 1'b0, {18'd0, 6'd20}, {6'd0, 6'd10}, {6'd0, 6'd20}, 4, 1'b0);

        // NxN all-zero modes, top[1]=10
        for (int i = 0; i < 4; i++) push(1'b0, 21'h0220E);
        for (int i = 0; i < 3; i++) push(1'b0, 21'h004BD);
        push(1'b1, 21'h004BD);
        run_cu("nxn_zero", 1'b1, 24'd0, 12'd0, {6'd10, 6'd0}, 13, 1'b0);

        // NxN mixed: PU0 idx0, PU1 rem9, PU2 rem0, PU3 idx2
        push(1'b0, 21'h0220E);
        push(1'b0, 21'h0020E);
        push(1'b0, 21'h0020E);
        push(1'b0, 21'h0220E);
        push(1'b0, 21'h004BD);
        push(1'b0, 21'h12ABB);
        push(1'b0, 21'h00ABB);
        push(1'b1, 21'h044BD);
        run_cu("nxn_mixed", 1'b1, {6'd0, 6'd1, 6'd10, 6'd26}, {6'd5, 6'd26}, {6'd18, 6'd26}, 13, 1'b0);

        // Back-pressure on the all-zero NxN case
        ready_mode = 1;
        for (int i = 0; i < 4; i++) push(1'b0, 21'h0220E);
        for (int i = 0; i < 3; i++) push(1'b0, 21'h004BD);
        push(1'b1, 21'h004BD);
        run_cu("nxn_bp", 1'b1, 24'd0, 12'd0, {6'd10, 6'd0}, 0, 1'b0);

        // Abort a CU during FLAG with reset, then run a clean CU
        ready_mode = 2;
        se_ready_i = 1'b0;
        @(posedge clk);
        #1;
        part_nxn_i  = 1'b1;
        cur_mode_i  = 24'd0;
        left_mode_i = 12'd0;
        top_mode_i  = {6'd10, 6'd0};
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k = 0;
        while (k < 50 && !se_valid_o) begin
            @(negedge clk);
            k++;
        end
        check("abort_valid_seen", {31'd0, se_valid_o}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_mode = 0;
        se_ready_i = 1'b1;
        push(1'b0, 21'h0220E);
        push(1'b1, 21'h004BD);
        run_cu("after_abort", 1'b0, {18'd0, 6'd26}, {6'd0, 6'd26}, {6'd0, 6'd26}, 4, 1'b1);
        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_idle_valid", {31'd0, se_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
